ex_muldiv: RTL
==============

# ex_muldiv

Parametrised iterative multiply/divide unit for the EX stage, successor to the fixed 32-bit divider. Executes signed/unsigned MULT and DIV on WIDTH-bit operands. Produces a HI/LO pair plus a HI/LO write strobe, and holds a stall request toward the pipeline while it works. Outputs are zero when idle, so they can be OR-merged with the other EX sub-unit results.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; legal values are 4 or greater.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  bit1 selects the operation (0 = multiply, 1 = divide); bit0 selects signedness (1 = signed).
- opa_i  in  WIDTH  multiplicand / dividend.
- opb_i  in  WIDTH  multiplier / divisor.
- cancel_i  in  1  flush; aborts any in-flight operation.
- stall_o  out  1  pipeline stall request.
- busy_o  out  1  high whenever the state is not IDLE.
- done_o  out  1  one-cycle result-valid pulse.
- hi_o  out  WIDTH  product high half / remainder; 0 unless done_o is high.
- lo_o  out  WIDTH  product low half / quotient; 0 unless done_o is high.
- whilo_o  out  1  HI/LO write enable; equals done_o.
- divzero_o  out  1  divide-by-zero flag; valid only while done_o is high.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE
  - If start_i=1 and cancel_i=0, latch operand magnitudes: two's-complement abs when op_i[0]=1, raw operands otherwise.
  - Latch the sign bits and op_i.
  - Set the counter to WIDTH and go to RUN.
  - Divide with opb_i=0: go directly to DONE with divzero_o=1, lo_o = all ones, hi_o = opa_i as supplied (no abs applied).
- RUN
  - One radix-2 step per cycle; the counter decrements each cycle. Go to FIX when the counter reaches 1 and that cycle's step is applied.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring division, {remainder, quotient} shift register, WIDTH+1-bit trial subtract.
- FIX
  - Signed multiply: negate the 2·WIDTH product if the sign bits differ.
  - Signed divide: quotient sign = signA XOR signB; remainder sign = signA.
  - All arithmetic is mod 2^WIDTH. Most-negative ÷ −1 gives quotient = most-negative, remainder = 0.
  - Go to DONE.
- DONE: drive done_o, whilo_o and the results for exactly one cycle, then return to IDLE.
- stall_o = (IDLE & start_i & ~cancel_i) | RUN | FIX. stall_o is low in DONE, so the instruction advances in the same cycle the result is presented.
- cancel_i=1 in RUN, FIX or DONE: go to IDLE on the next edge with no done_o. If done_o is already high that cycle it is still driven, and the pipeline must qualify it.
- cancel_i has priority over start_i.
- start_i outside IDLE is ignored.
- Reset, including mid-operation: state IDLE, counter 0, all datapath registers 0, all outputs 0.

## Timing
- Cycle 0 is the cycle in which start_i is sampled in IDLE.
- Iterative path: RUN occupies cycles 1..WIDTH, FIX is cycle WIDTH+1, done_o is high in cycle WIDTH+2 (34 for WIDTH=32).
- Divide by zero: done_o is high in cycle 1.
- stall_o is high in cycles 0..WIDTH+1 and low in cycle WIDTH+2.
- A back-to-back operation can start in the cycle after DONE at the earliest.
- All outputs are combinational decodes of registered state; no input-to-output path exists except stall_o ← start_i/cancel_i in IDLE.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - Multiply uses a single-cycle WIDTH×WIDTH signed/unsigned product registered at the cycle-0 edge, going IDLE→DONE.
  - done_o is high in cycle 1; stall_o is high in cycle 0 only.
  - Divide is unchanged.
- MULDIV_FAST_MUL_EN undefined: multiply uses the iterative path with WIDTH+2 latency. There is no hardware multiplier.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001, whilo_o=1. done_o in cycle 34 without the macro, cycle 1 with it.
- MULT −3 × 7 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. DIVU 7 ÷ 2 → lo_o=3, hi_o=1.
- DIV −7 ÷ 2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIV 0x1234 ÷ 0 → done_o and divzero_o high in cycle 1, lo_o=0xFFFFFFFF, hi_o=0x1234.
- DIVU started, cancel_i pulsed in cycle 10 → busy_o=0 and stall_o=0 in cycle 11, no done_o. Also: start_i asserted in cycle 5 of another operation → ignored.
- rst driven low asynchronously mid-RUN → all outputs 0 immediately. After release, a new MULTU 2×3 → lo_o=6, hi_o=0.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the EX stage and the iterative
// multiply/divide unit.
//   master : pipeline side, drives start/op/operands/cancel, sees results.
//   slave  : the ex_muldiv unit.
// Signals:
//   start_i   request a new operation (sampled only while the unit is idle)
//   op_i      [1]=divide, [0]=signed
//   opa_i     multiplicand / dividend
//   opb_i     multiplier / divisor
//   cancel_i  flush, aborts any in-flight operation
//   stall_o   stall request toward the pipeline
//   busy_o    unit not idle
//   done_o    one-cycle result-valid pulse
//   hi_o      product high half / remainder (0 unless done_o)
//   lo_o      product low half / quotient (0 unless done_o)
//   whilo_o   HI/LO write strobe (equals done_o)
//   divzero_o divide-by-zero flag (qualified by done_o)
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             cancel_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             whilo_o;
  logic             divzero_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, cancel_i,
    input  stall_o, busy_o, done_o, hi_o, lo_o, whilo_o, divzero_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, cancel_i,
    output stall_o, busy_o, done_o, hi_o, lo_o, whilo_o, divzero_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative signed/unsigned multiply and divide for the EX stage.
// Radix-2: one shift-add (multiply) or restoring-subtract (divide) step per
// cycle on operand magnitudes, followed by a sign-fix cycle. Results are
// presented for one cycle in DONE and are zero otherwise so they can be
// OR-merged with the other EX results.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  ex_muldiv_if.slave (start/op/operands/cancel in; stall/busy/done,
//        hi/lo, whilo, divzero out)
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies use a single-cycle
//                       WIDTH x WIDTH product (IDLE -> DONE); divide unchanged.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt,   w_cnt_nxt;
  // Multiply: {product hi, product lo / remaining multiplier bits}.
  // Divide:   {remainder, quotient / remaining dividend bits}.
  logic [2*WIDTH-1:0] r_acc,   w_acc_nxt;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   r_opd,   w_opd_nxt;
  logic               r_div,   w_div_nxt;
  logic               r_sa,    w_sa_nxt;
  logic               r_sb,    w_sb_nxt;
  logic               r_dz,    w_dz_nxt;

  logic               w_start;
  logic               w_sa_in, w_sb_in;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH:0]     w_sum, w_trial;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic               w_done;

  assign w_start = bus.start_i & ~bus.cancel_i;

  // Sign bits only count for signed ops, so unsigned ops pass through FIX
  // untouched.
  assign w_sa_in = bus.op_i[0] & bus.opa_i[WIDTH-1];
  assign w_sb_in = bus.op_i[0] & bus.opb_i[WIDTH-1];
  assign w_a_abs = w_sa_in ? -bus.opa_i : bus.opa_i;
  assign w_b_abs = w_sb_in ? -bus.opb_i : bus.opb_i;

  // Shift-add: carry out of the upper half lands in the MSB after the shift.
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
  // Trial subtract on {remainder, next dividend bit}; bit WIDTH set means
  // the divisor did not fit.
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};

  assign w_quo_fix  = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_prod_fix = (r_sa ^ r_sb) ? -r_acc : r_acc;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     w_fa, w_fb;
  logic signed [2*WIDTH+1:0] w_fprod;
  assign w_fa    = {w_sa_in, bus.opa_i};
  assign w_fb    = {w_sb_in, bus.opb_i};
  assign w_fprod = w_fa * w_fb;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_opd_nxt   = r_opd;
    w_div_nxt   = r_div;
    w_sa_nxt    = r_sa;
    w_sb_nxt    = r_sb;
    w_dz_nxt    = r_dz;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_div_nxt   = bus.op_i[1];
          w_sa_nxt    = w_sa_in;
          w_sb_nxt    = w_sb_in;
          w_dz_nxt    = 1'b0;
          w_cnt_nxt   = CW'(WIDTH);
          w_state_nxt = RUN;
          if (bus.op_i[1]) begin
            w_acc_nxt = {{WIDTH{1'b0}}, w_a_abs};
            w_opd_nxt = w_b_abs;
            if (bus.opb_i == '0) begin
              // Raw dividend goes to HI, no abs applied.
              w_acc_nxt   = {bus.opa_i, {WIDTH{1'b1}}};
              w_dz_nxt    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = DONE;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            w_acc_nxt   = w_fprod[2*WIDTH-1:0];
            w_cnt_nxt   = '0;
            w_state_nxt = DONE;
`else
            w_acc_nxt = {{WIDTH{1'b0}}, w_b_abs};
            w_opd_nxt = w_a_abs;
`endif
          end
        end
      end
      RUN: begin
        if (bus.cancel_i) begin
          w_state_nxt = IDLE;
        end else begin
          if (r_div) begin
            if (!w_trial[WIDTH])
              w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
              w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
          end else begin
            if (r_acc[0])
              w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
            else
              w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
          end
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            w_state_nxt = FIX;
        end
      end
      FIX: begin
        if (bus.cancel_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_acc_nxt   = r_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_opd   <= w_opd_nxt;
      r_div   <= w_div_nxt;
      r_sa    <= w_sa_nxt;
      r_sb    <= w_sb_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  assign w_done        = (r_state == DONE);
  assign bus.done_o    = w_done;
  assign bus.whilo_o   = w_done;
  assign bus.divzero_o = w_done & r_dz;
  assign bus.hi_o      = w_done ? r_acc[2*WIDTH-1:WIDTH] : '0;
  assign bus.lo_o      = w_done ? r_acc[WIDTH-1:0]       : '0;
  assign bus.busy_o    = (r_state != IDLE);
  // Low in DONE so the instruction retires with its result.
  assign bus.stall_o   = ((r_state == IDLE) & w_start) | (r_state == RUN) | (r_state == FIX);

endmodule
